// File: rtl/cc_stall_replay_buffer_pkg.sv
// Shared coherence definitions for the stall/replay buffer.
//   - coherence_state_t / coherence_request_t : line states and request kinds
//   - cc_stall_entry_t                        : one parked request
//   - cc_stall_lookup()                       : 1 when (state, request) must stall
//   - CC_ADDR_W / CC_PAYLOAD_W                : storage widths of a parked entry
package cc_stall_replay_buffer_pkg;

    localparam int CC_ADDR_W    = 26;
    localparam int CC_PAYLOAD_W = 64;

    typedef enum logic [3:0] {
        CS_I    = 4'd0,
        CS_S    = 4'd1,
        CS_M    = 4'd2,
        CS_ISD  = 4'd3,
        CS_IMAD = 4'd4,
        CS_IMD  = 4'd5,
        CS_IMA  = 4'd6,
        CS_IUD  = 4'd7,
        CS_SMAD = 4'd8,
        CS_SMA  = 4'd9,
        CS_MIA  = 4'd10,
        CS_SIA  = 4'd11,
        CS_IIA  = 4'd12
    } coherence_state_t;

    typedef enum logic [3:0] {
        CR_LOAD            = 4'd0,
        CR_STORE           = 4'd1,
        CR_REPLACEMENT     = 4'd2,
        CR_RECALL          = 4'd3,
        CR_FLUSH           = 4'd4,
        CR_FWD_FLUSH       = 4'd5,
        CR_INV             = 4'd6,
        CR_FWD_GETS        = 4'd7,
        CR_FWD_GETM        = 4'd8,
        CR_LOAD_UNC        = 4'd9,
        CR_STORE_UNC       = 4'd10,
        CR_REPLACEMENT_UNC = 4'd11,
        CR_FLUSH_UNC       = 4'd12
    } coherence_request_t;

    typedef struct packed {
        coherence_request_t        req_type;
        logic [CC_ADDR_W-1:0]      address;
        logic [CC_PAYLOAD_W-1:0]   payload;
        logic                      woken;
    } cc_stall_entry_t;

    // Transient states block the requests that would race the pending
    // transaction; stable states (I, S, M) never stall.
    function automatic logic cc_stall_lookup(input coherence_state_t state,
                                             input coherence_request_t req);
        logic stall;
        stall = 1'b0;
        case (state)
            CS_ISD:
                stall = req inside {CR_LOAD, CR_STORE, CR_REPLACEMENT, CR_RECALL,
                                    CR_FWD_FLUSH, CR_INV};
            CS_IMAD, CS_IMD, CS_IMA:
                stall = req inside {CR_FLUSH, CR_LOAD, CR_STORE, CR_REPLACEMENT,
                                    CR_RECALL, CR_FWD_FLUSH, CR_FWD_GETS, CR_FWD_GETM};
            CS_IUD:
                stall = req inside {CR_LOAD_UNC, CR_STORE_UNC, CR_REPLACEMENT_UNC,
                                    CR_FLUSH_UNC};
            CS_SMAD, CS_SMA:
                stall = req inside {CR_FLUSH, CR_STORE, CR_REPLACEMENT, CR_FWD_FLUSH,
                                    CR_FWD_GETS, CR_FWD_GETM};
            CS_MIA, CS_SIA:
                stall = req inside {CR_LOAD, CR_STORE, CR_REPLACEMENT};
            CS_IIA:
                stall = req inside {CR_LOAD, CR_STORE, CR_RECALL, CR_REPLACEMENT};
            default:
                stall = 1'b0;
        endcase
        return stall;
    endfunction

endpackage

// File: rtl/cc_stall_replay_buffer_if.sv
// Bus between the cache controller (master) and the stall/replay buffer (slave).
//   req_*    : request classification / park channel
//   upd_*    : line state change notifications (no handshake, one per cycle)
//   replay_* : parked request reissue channel
//   occupancy / full : buffer status
// Handshakes: a request is parked on the cycle where req_valid & req_stall &
// req_ready are all high; with req_stall & !req_ready the master must hold the
// request. A replay transfers on replay_valid & replay_ready; while
// replay_valid is high without replay_ready the slave keeps replay_* stable,
// unless a newer update makes that entry stall again.
interface cc_stall_replay_buffer_if #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 26,
    parameter int PAYLOAD_W = 64
);
    import cc_stall_replay_buffer_pkg::*;

    logic                          req_valid;
    coherence_state_t              req_state;
    coherence_request_t            req_type;
    logic [ADDR_W-1:0]             req_address;
    logic [PAYLOAD_W-1:0]          req_payload;
    logic                          req_stall;
    logic                          req_ready;

    logic                          upd_valid;
    logic [ADDR_W-1:0]             upd_address;
    coherence_state_t              upd_state;

    logic                          replay_valid;
    logic                          replay_ready;
    coherence_request_t            replay_type;
    logic [ADDR_W-1:0]             replay_address;
    logic [PAYLOAD_W-1:0]          replay_payload;

    logic [$clog2(DEPTH+1)-1:0]    occupancy;
    logic                          full;

    modport master (
        output req_valid, req_state, req_type, req_address, req_payload,
        output upd_valid, upd_address, upd_state, replay_ready,
        input  req_stall, req_ready, replay_valid, replay_type,
        input  replay_address, replay_payload, occupancy, full
    );

    modport slave (
        input  req_valid, req_state, req_type, req_address, req_payload,
        input  upd_valid, upd_address, upd_state, replay_ready,
        output req_stall, req_ready, replay_valid, replay_type,
        output replay_address, replay_payload, occupancy, full
    );

endinterface

// File: rtl/cc_stall_entry_select.sv
// Replay candidate selection for the parked-request buffer.
//   valid / woken : per-entry status
//   address       : per-entry line address
//   age[i][j]     : entry j was parked before entry i and is still present
//   eligible      : woken entries with no older entry to the same line
//   grant         : lowest-index eligible entry, one-hot (zero when none)
module cc_stall_entry_select
    import cc_stall_replay_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]     valid,
    input  logic [DEPTH-1:0]     woken,
    input  logic [CC_ADDR_W-1:0] address [DEPTH],
    input  logic [DEPTH-1:0]     age [DEPTH],
    output logic [DEPTH-1:0]     eligible,
    output logic [DEPTH-1:0]     grant
);

    logic [DEPTH-1:0] blocked;

    always_comb begin
        blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (age[i][j] && valid[j] && (address[j] == address[i])) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        eligible = valid & woken & ~blocked;
        // Isolate the lowest set bit.
        grant    = eligible & (~eligible + DEPTH'(1));
    end

endmodule

// File: rtl/cc_stall_replay_buffer.sv
// Stall decision and replay buffer for the L1 cache controller.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of cc_stall_replay_buffer_if
// A request that hits the stall table, or whose line already has a parked
// request, is parked in the lowest free slot. Line updates recompute the
// woken flag of every parked request to that line; woken requests replay
// oldest-first per line, lowest slot first across lines.
// ADDR_W / PAYLOAD_W must not exceed CC_ADDR_W / CC_PAYLOAD_W.
module cc_stall_replay_buffer
    import cc_stall_replay_buffer_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = CC_ADDR_W,
    parameter int PAYLOAD_W = CC_PAYLOAD_W
) (
    input  logic                    clk,
    input  logic                    reset,
    cc_stall_replay_buffer_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    cc_stall_entry_t          entries [DEPTH];
    logic [DEPTH-1:0]         valid;
    logic [DEPTH-1:0]         age [DEPTH];
    logic [DEPTH-1:0]         hold_mask;

    logic [CC_ADDR_W-1:0]     entry_addr [DEPTH];
    logic [DEPTH-1:0]         woken_vec;
    logic [DEPTH-1:0]         eligible;
    logic [DEPTH-1:0]         lowest_grant;
    logic [DEPTH-1:0]         grant;
    logic [DEPTH-1:0]         deq_mask;

    logic [CC_ADDR_W-1:0]     req_addr_ext;
    logic [CC_ADDR_W-1:0]     upd_addr_ext;
    logic                     conflict;
    logic                     stall;
    logic                     enq;
    logic                     replay_valid;
    logic [IDX_W-1:0]         alloc_idx;
    logic [CNT_W-1:0]         occ;
    cc_stall_entry_t          new_entry;

    coherence_request_t       rep_type;
    logic [CC_ADDR_W-1:0]     rep_addr;
    logic [CC_PAYLOAD_W-1:0]  rep_payload;

    assign req_addr_ext = CC_ADDR_W'(bus.req_address);
    assign upd_addr_ext = CC_ADDR_W'(bus.upd_address);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = entries[i].address;
            woken_vec[i]  = entries[i].woken;
        end
    end

    cc_stall_entry_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .valid    (valid),
        .woken    (woken_vec),
        .address  (entry_addr),
        .age      (age),
        .eligible (eligible),
        .grant    (lowest_grant)
    );

    // A presented replay keeps its slot until accepted, even if a lower slot
    // becomes eligible meanwhile; it only drops if its own entry is re-cleared.
    assign grant        = (|(hold_mask & eligible)) ? hold_mask : lowest_grant;
    assign replay_valid = |grant;
    assign deq_mask     = (replay_valid && bus.replay_ready) ? grant : '0;

    // Occupancy, line conflict and lowest free slot, all from current state.
    always_comb begin
        occ       = '0;
        conflict  = 1'b0;
        alloc_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + CNT_W'(valid[i]);
            if (valid[i] && (entries[i].address == req_addr_ext)) begin
                conflict = 1'b1;
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign stall = bus.req_valid & (cc_stall_lookup(bus.req_state, bus.req_type) | conflict);
    assign enq   = stall & (occ != CNT_W'(DEPTH));

    // A same-cycle update to the new request's line decides its woken flag.
    always_comb begin
        new_entry          = '0;
        new_entry.req_type = bus.req_type;
        new_entry.address  = req_addr_ext;
        new_entry.payload  = CC_PAYLOAD_W'(bus.req_payload);
        new_entry.woken    = bus.upd_valid && (upd_addr_ext == req_addr_ext) &&
                             !cc_stall_lookup(bus.upd_state, bus.req_type);
    end

    always_comb begin
        rep_type    = CR_LOAD;
        rep_addr    = '0;
        rep_payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                rep_type    = entries[i].req_type;
                rep_addr    = entries[i].address;
                rep_payload = entries[i].payload;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            hold_mask <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
                age[i]     <= '0;
            end
        end else begin
            hold_mask <= (replay_valid && !bus.replay_ready) ? grant : '0;
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= age[i] & ~deq_mask;
                if (deq_mask[i]) begin
                    valid[i] <= 1'b0;
                end else if (bus.upd_valid && valid[i] &&
                             (entries[i].address == upd_addr_ext)) begin
                    entries[i].woken <= !cc_stall_lookup(bus.upd_state, entries[i].req_type);
                end
            end
            if (enq) begin
                valid[alloc_idx]   <= 1'b1;
                entries[alloc_idx] <= new_entry;
                // An entry leaving this cycle is not older than anything.
                age[alloc_idx]     <= valid & ~deq_mask;
            end
        end
    end

    assign bus.req_stall      = stall;
    assign bus.req_ready      = (occ != CNT_W'(DEPTH));
    assign bus.replay_valid   = replay_valid;
    assign bus.replay_type    = rep_type;
    assign bus.replay_address = ADDR_W'(rep_addr);
    assign bus.replay_payload = PAYLOAD_W'(rep_payload);
    assign bus.occupancy      = occ;
    assign bus.full           = (occ == CNT_W'(DEPTH));

endmodule

// File: tb/tb_cc_stall_replay_buffer.sv
// Bench for cc_stall_replay_buffer: directed scenarios followed by random
// traffic, both checked cycle by cycle against a slot/sequence reference model.
module tb_cc_stall_replay_buffer;
    import cc_stall_replay_buffer_pkg::*;

    localparam int DEPTH     = 8;
    localparam int ADDR_W    = 26;
    localparam int PAYLOAD_W = 64;

    logic clk;
    logic reset;

    cc_stall_replay_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    cc_stall_replay_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters / compare ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- stall table ----------------
    bit tbl [16][16];

    function automatic logic [15:0] bm(input coherence_request_t t);
        return 16'd1 << int'(t);
    endfunction

    task automatic mark(input coherence_state_t s, input logic [15:0] m);
        for (int k = 0; k < 16; k++) if (m[k]) tbl[s][k] = 1'b1;
    endtask

    task automatic init_tbl();
        logic [15:0] im, sm;
        mark(CS_ISD, bm(CR_LOAD) | bm(CR_STORE) | bm(CR_REPLACEMENT) | bm(CR_RECALL) |
                     bm(CR_FWD_FLUSH) | bm(CR_INV));
        im = bm(CR_FLUSH) | bm(CR_LOAD) | bm(CR_STORE) | bm(CR_REPLACEMENT) | bm(CR_RECALL) |
             bm(CR_FWD_FLUSH) | bm(CR_FWD_GETS) | bm(CR_FWD_GETM);
        mark(CS_IMAD, im);
        mark(CS_IMD, im);
        mark(CS_IMA, im);
        mark(CS_IUD, bm(CR_LOAD_UNC) | bm(CR_STORE_UNC) | bm(CR_REPLACEMENT_UNC) | bm(CR_FLUSH_UNC));
        sm = bm(CR_FLUSH) | bm(CR_STORE) | bm(CR_REPLACEMENT) | bm(CR_FWD_FLUSH) |
             bm(CR_FWD_GETS) | bm(CR_FWD_GETM);
        mark(CS_SMAD, sm);
        mark(CS_SMA, sm);
        mark(CS_MIA, bm(CR_LOAD) | bm(CR_STORE) | bm(CR_REPLACEMENT));
        mark(CS_SIA, bm(CR_LOAD) | bm(CR_STORE) | bm(CR_REPLACEMENT));
        mark(CS_IIA, bm(CR_LOAD) | bm(CR_STORE) | bm(CR_RECALL) | bm(CR_REPLACEMENT));
    endtask

    // ---------------- reference model ----------------
    // Parked requests live in slots; per-line order is tracked by a global
    // arrival sequence number.
    bit                      m_valid [DEPTH];
    coherence_request_t      m_type  [DEPTH];
    logic [ADDR_W-1:0]       m_addr  [DEPTH];
    logic [PAYLOAD_W-1:0]    m_pay   [DEPTH];
    bit                      m_woken [DEPTH];
    int                      m_seq   [DEPTH];
    int                      m_hold;
    int                      seq_ctr;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_woken[i] = 1'b0;
        end
        m_hold = -1;
    endtask

    function automatic bit m_elig(input int i);
        if (!m_valid[i] || !m_woken[i]) return 1'b0;
        for (int j = 0; j < DEPTH; j++)
            if (j != i && m_valid[j] && m_addr[j] == m_addr[i] && m_seq[j] < m_seq[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        bit                    stall;
        bit                    ready;
        bit                    rvalid;
        coherence_request_t    rtype;
        logic [ADDR_W-1:0]     raddr;
        logic [PAYLOAD_W-1:0]  rpay;
        int                    occ;
        bit                    full;
        bit                    in_reset;
    } exp_t;

    exp_t exp_q [$];

    // ---------------- driver ----------------
    task automatic apply(input bit rv, input coherence_state_t rs, input coherence_request_t rt,
                         input logic [ADDR_W-1:0] ra, input logic [PAYLOAD_W-1:0] rp,
                         input bit uv, input logic [ADDR_W-1:0] ua, input coherence_state_t us,
                         input bit rr);
        exp_t e;
        int   occ, pres, slot;
        bit   conflict;
        reset           = 1'b0;
        bus.req_valid   = rv;
        bus.req_state   = rs;
        bus.req_type    = rt;
        bus.req_address = ra;
        bus.req_payload = rp;
        bus.upd_valid   = uv;
        bus.upd_address = ua;
        bus.upd_state   = us;
        bus.replay_ready = rr;

        occ = 0;
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i]) begin
                occ++;
                if (m_addr[i] == ra) conflict = 1'b1;
            end
        pres = -1;
        if (m_hold >= 0 && m_elig(m_hold)) pres = m_hold;
        else for (int i = 0; i < DEPTH; i++) if (pres < 0 && m_elig(i)) pres = i;

        e.stall    = rv && (tbl[rs][rt] || conflict);
        e.occ      = occ;
        e.full     = (occ == DEPTH);
        e.ready    = !e.full;
        e.rvalid   = (pres >= 0);
        e.rtype    = (pres >= 0) ? m_type[pres] : CR_LOAD;
        e.raddr    = (pres >= 0) ? m_addr[pres] : '0;
        e.rpay     = (pres >= 0) ? m_pay[pres]  : '0;
        e.in_reset = 1'b0;
        exp_q.push_back(e);

        slot = -1;
        for (int i = 0; i < DEPTH; i++) if (slot < 0 && !m_valid[i]) slot = i;
        if (uv)
            for (int i = 0; i < DEPTH; i++)
                if (m_valid[i] && m_addr[i] == ua) m_woken[i] = !tbl[us][m_type[i]];
        if (pres >= 0 && rr) m_valid[pres] = 1'b0;
        m_hold = (pres >= 0 && !rr) ? pres : -1;
        if (e.stall && e.ready) begin
            m_valid[slot] = 1'b1;
            m_type[slot]  = rt;
            m_addr[slot]  = ra;
            m_pay[slot]   = rp;
            m_woken[slot] = uv && (ua == ra) && !tbl[us][rt];
            m_seq[slot]   = seq_ctr;
            seq_ctr++;
        end
    endtask

    task automatic rst_cycle();
        exp_t e;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.upd_valid    = 1'b0;
        bus.replay_ready = 1'b1;
        model_clear();
        e.stall = 1'b0; e.ready = 1'b1; e.rvalid = 1'b0; e.rtype = CR_LOAD;
        e.raddr = '0; e.rpay = '0; e.occ = 0; e.full = 1'b0; e.in_reset = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #2;
    endtask

    task automatic req(input coherence_state_t rs, input coherence_request_t rt,
                       input logic [ADDR_W-1:0] ra, input bit rr);
        apply(1'b1, rs, rt, ra, {32'hC0DE_0000, 32'(seq_ctr)}, 1'b0, '0, CS_I, rr);
    endtask

    task automatic upd(input logic [ADDR_W-1:0] ua, input coherence_state_t us, input bit rr);
        apply(1'b0, CS_I, CR_LOAD, '0, '0, 1'b1, ua, us, rr);
    endtask

    task automatic idle(input bit rr);
        apply(1'b0, CS_I, CR_LOAD, '0, '0, 1'b0, '0, CS_I, rr);
    endtask

    // ---------------- monitor ----------------
    exp_t me;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("req_stall",    64'(bus.req_stall),    64'(me.stall));
            chk("req_ready",    64'(bus.req_ready),    64'(me.ready));
            chk("occupancy",    64'(bus.occupancy),    64'(me.occ));
            chk("full",         64'(bus.full),         64'(me.full));
            chk("replay_valid", 64'(bus.replay_valid), 64'(me.rvalid));
            if (me.rvalid || me.in_reset) begin
                chk("replay_type",    64'(bus.replay_type),    64'(me.rtype));
                chk("replay_address", 64'(bus.replay_address), 64'(me.raddr));
                chk("replay_payload", 64'(bus.replay_payload), 64'(me.rpay));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [ADDR_W-1:0] pool [4];

    initial begin
        bit                 rv, uv, rr;
        coherence_state_t   rs, us;
        coherence_request_t rt;

        pool[0] = 26'h100; pool[1] = 26'h200; pool[2] = 26'h300; pool[3] = 26'h140;
        seq_ctr = 0;
        init_tbl();
        model_clear();
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_state = CS_I; bus.req_type = CR_LOAD;
        bus.req_address = '0; bus.req_payload = '0;
        bus.upd_valid = 1'b0; bus.upd_address = '0; bus.upd_state = CS_I;
        bus.replay_ready = 1'b0;
        step();

        // reset values
        rst_cycle(); peek();
        chk("rst_replay_valid", 64'(bus.replay_valid), 64'd0);
        chk("rst_occupancy",    64'(bus.occupancy),    64'd0);
        chk("rst_req_ready",    64'(bus.req_ready),    64'd1);
        step();

        // classification
        req(CS_IMAD, CR_LOAD, 26'h700, 1'b0); peek();
        chk("cls_imad_load", 64'(bus.req_stall), 64'd1); step();
        req(CS_SMAD, CR_LOAD, 26'h710, 1'b0); peek();
        chk("cls_smad_load", 64'(bus.req_stall), 64'd0); step();
        req(CS_IUD, CR_STORE_UNC, 26'h720, 1'b0); peek();
        chk("cls_iud_store_unc", 64'(bus.req_stall), 64'd1); step();
        rst_cycle(); step();

        // park and wake
        req(CS_ISD, CR_LOAD, 26'h100, 1'b0); step();
        upd(26'h100, CS_S, 1'b0); peek();
        chk("pw_occ1", 64'(bus.occupancy), 64'd1);
        chk("pw_no_early_replay", 64'(bus.replay_valid), 64'd0); step();
        idle(1'b1); peek();
        chk("pw_replay_valid", 64'(bus.replay_valid), 64'd1);
        chk("pw_replay_addr",  64'(bus.replay_address), 64'h100);
        chk("pw_replay_type",  64'(bus.replay_type), 64'(CR_LOAD)); step();
        idle(1'b0); peek();
        chk("pw_occ0", 64'(bus.occupancy), 64'd0); step();

        // per-line ordering
        req(CS_IMA, CR_STORE, 26'h200, 1'b0); step();
        req(CS_S, CR_LOAD, 26'h200, 1'b0); peek();
        chk("ord_conflict_stall", 64'(bus.req_stall), 64'd1); step();
        upd(26'h200, CS_M, 1'b0); step();
        idle(1'b1); peek();
        chk("ord_first_store", 64'(bus.replay_type), 64'(CR_STORE)); step();
        idle(1'b1); peek();
        chk("ord_second_load", 64'(bus.replay_type), 64'(CR_LOAD)); step();

        // non-waking update
        req(CS_SMA, CR_STORE, 26'h300, 1'b0); step();
        upd(26'h300, CS_SMA, 1'b0); step();
        upd(26'h300, CS_M, 1'b0); peek();
        chk("nw_no_replay", 64'(bus.replay_valid), 64'd0); step();
        idle(1'b1); peek();
        chk("nw_replay", 64'(bus.replay_valid), 64'd1); step();

        // full buffer
        for (int i = 0; i < DEPTH; i++) begin
            req(CS_ISD, CR_LOAD, 26'h400 + 26'(i), 1'b0); step();
        end
        req(CS_ISD, CR_LOAD, 26'h500, 1'b0); peek();
        chk("full_flag",  64'(bus.full), 64'd1);
        chk("full_ready", 64'(bus.req_ready), 64'd0); step();
        upd(26'h400, CS_S, 1'b0); peek();
        chk("full_not_stored", 64'(bus.occupancy), 64'd8); step();
        idle(1'b1); peek();
        chk("full_replay_addr", 64'(bus.replay_address), 64'h400); step();
        idle(1'b0); peek();
        chk("full_ready_again", 64'(bus.req_ready), 64'd1); step();

        // reset with parked and woken entries
        rst_cycle(); step();
        req(CS_ISD, CR_LOAD, 26'h100, 1'b0); step();
        req(CS_ISD, CR_LOAD, 26'h200, 1'b0); step();
        req(CS_ISD, CR_LOAD, 26'h300, 1'b0); step();
        upd(26'h100, CS_S, 1'b0); step();
        upd(26'h200, CS_S, 1'b0); step();
        idle(1'b0); peek();
        chk("mid_pre_valid", 64'(bus.replay_valid), 64'd1); step();
        rst_cycle(); peek();
        chk("mid_rst_valid", 64'(bus.replay_valid), 64'd0);
        chk("mid_rst_occ",   64'(bus.occupancy),    64'd0); step();
        rst_cycle(); step();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1); peek();
            chk("mid_after_release", 64'(bus.replay_valid), 64'd0); step();
        end

        // random traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_cycle(); step();
            end else begin
                rv = ($urandom_range(0, 99) < 55);
                rs = coherence_state_t'(4'($urandom_range(0, 12)));
                rt = coherence_request_t'(4'($urandom_range(0, 12)));
                uv = ($urandom_range(0, 99) < 35);
                if ($urandom_range(0, 99) < 60) us = coherence_state_t'(4'($urandom_range(0, 2)));
                else                            us = coherence_state_t'(4'($urandom_range(0, 12)));
                rr = ($urandom_range(0, 99) < 60);
                apply(rv, rs, rt, pool[$urandom_range(0, 3)], {$urandom, $urandom},
                      uv, pool[$urandom_range(0, 3)], us, rr);
                step();
            end
        end

        idle(1'b1); step();
        #10;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
